// File: rtl/cache_pkg.sv
// Shared L1 geometry, beat parameters and miss-handler state encoding.
package cache_pkg;

   localparam int ADDR_WIDTH   = 32;
   localparam int DATA_WIDTH   = 32;
   localparam int L1_LINE_SIZE = 32;
   localparam int L1_OFFSET    = $clog2(L1_LINE_SIZE);
   localparam int L1_INDEX     = 8;
   localparam int L1_TAG       = ADDR_WIDTH - L1_INDEX - L1_OFFSET;
   localparam int L1_DATABITS  = L1_LINE_SIZE * 8;
   localparam int L1_BEATS     = L1_LINE_SIZE / (DATA_WIDTH / 8);
   localparam int L1_BEAT_BITS = $clog2(L1_BEATS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      RD   = 2'd2,
      FILL = 2'd3
   } l1_mh_state_t;

   // Line-aligned address (offset bits cleared).
   function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
      return addr & ~(ADDR_WIDTH'(L1_LINE_SIZE - 1));
   endfunction

endpackage

// File: rtl/l1_miss_handler_if.sv
// Miss, next-level memory and refill signals between L1 and the miss handler.
interface l1_miss_handler_if;
   import cache_pkg::*;

   logic                   miss_valid;
   logic                   miss_ready;
   logic [ADDR_WIDTH-1:0]  miss_addr;
   logic                   wb_en;
   logic [L1_TAG-1:0]      wb_tag;
   logic [L1_DATABITS-1:0] wb_data;

   logic                   mem_req_valid;
   logic                   mem_req_ready;
   logic                   mem_req_we;
   logic [ADDR_WIDTH-1:0]  mem_req_addr;
   logic [DATA_WIDTH-1:0]  mem_req_wdata;
   logic                   mem_rsp_valid;
   logic [DATA_WIDTH-1:0]  mem_rsp_rdata;

   logic                   fill_valid;
   logic                   fill_ready;
   logic [ADDR_WIDTH-1:0]  fill_addr;
   logic [L1_DATABITS-1:0] fill_data;
   logic                   busy;

   // Handler side.
   modport master (
      input  miss_valid, miss_addr, wb_en, wb_tag, wb_data,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, fill_ready,
      output miss_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      output fill_valid, fill_addr, fill_data, busy
   );

   // L1 controller / memory side.
   modport slave (
      output miss_valid, miss_addr, wb_en, wb_tag, wb_data,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, fill_ready,
      input  miss_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      input  fill_valid, fill_addr, fill_data, busy
   );

endinterface

// File: rtl/l1_line_buffer.sv
// One cache line of storage: whole-line load, word write by index,
// word read by index and the full line out.
module l1_line_buffer #(
   parameter int WORDS  = 8,
   parameter int IDX_W  = 3,
   parameter int WORD_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_en,
   input  logic [WORDS*WORD_W-1:0] load_line,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [WORD_W-1:0]       wr_word,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [WORD_W-1:0]       rd_word,
   output logic [WORDS*WORD_W-1:0] line
);

   logic [WORDS*WORD_W-1:0] line_q;

   // Whole-line load wins; otherwise a single word is overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
      end else if (load_en) begin
         line_q <= load_line;
      end else if (wr_en) begin
         line_q[wr_idx*WORD_W +: WORD_W] <= wr_word;
      end
   end

   assign rd_word = line_q[rd_idx*WORD_W +: WORD_W];
   assign line    = line_q;

endmodule

// File: rtl/l1_miss_handler.sv
// L1 miss handler: optional dirty write-back, line read, refill to L1.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a miss; miss_ready high
// WB    | issuing BEATS write beats of the dirty victim line
// RD    | issuing BEATS read beats and collecting responses in order
// FILL  | presenting the assembled line until fill_ready
module l1_miss_handler import cache_pkg::*; #(
   parameter int BEATS  = L1_LINE_SIZE / (DATA_WIDTH / 8),
   parameter int BEAT_W = $clog2(BEATS)
) (
   input logic               clk,
   input logic               rst_n,
   l1_miss_handler_if.master bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_WB   = WB;
   localparam logic [1:0] S_RD   = RD;
   localparam logic [1:0] S_FILL = FILL;

   localparam int              LAST_BEAT = BEATS - 1;
   localparam logic [BEAT_W:0] CNT_LAST  = LAST_BEAT[BEAT_W:0];
   localparam logic [BEAT_W:0] CNT_DONE  = BEATS[BEAT_W:0];

   logic [1:0]             state_q;
   logic [BEAT_W:0]        req_cnt_q;
   logic [BEAT_W:0]        rsp_cnt_q;
   logic [ADDR_WIDTH-1:0]  fill_addr_q;
   logic [L1_TAG-1:0]      wb_tag_q;
   logic                   fill_valid_q;

   logic                   miss_take;
   logic                   req_valid;
   logic                   req_hs;
   logic                   rsp_take;
   logic [BEAT_W-1:0]      req_idx;
   logic [BEAT_W-1:0]      rsp_idx;
   logic [DATA_WIDTH-1:0]  rd_word;
   logic [L1_DATABITS-1:0] line;

   assign miss_take = (state_q == S_IDLE) && bus.miss_valid;
   assign req_valid = ((state_q == S_WB) || (state_q == S_RD)) && (req_cnt_q != CNT_DONE);
   assign req_hs    = req_valid && bus.mem_req_ready;
   // Responses outside RD or beyond the line are dropped.
   assign rsp_take  = (state_q == S_RD) && bus.mem_rsp_valid && (rsp_cnt_q != CNT_DONE);
   assign req_idx   = req_cnt_q[BEAT_W-1:0];
   assign rsp_idx   = rsp_cnt_q[BEAT_W-1:0];

   // Sequencing FSM with independent request and response beat counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         req_cnt_q    <= '0;
         rsp_cnt_q    <= '0;
         fill_addr_q  <= '0;
         wb_tag_q     <= '0;
         fill_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (miss_take) begin
                  fill_addr_q <= line_base(bus.miss_addr);
                  wb_tag_q    <= bus.wb_tag;
                  req_cnt_q   <= '0;
                  rsp_cnt_q   <= '0;
                  state_q     <= bus.wb_en ? S_WB : S_RD;
               end
            end
            S_WB: begin
               if (req_hs) begin
                  if (req_cnt_q == CNT_LAST) begin
                     req_cnt_q <= '0;
                     state_q   <= S_RD;
                  end else begin
                     req_cnt_q <= req_cnt_q + 1'b1;
                  end
               end
            end
            S_RD: begin
               if (req_hs) begin
                  req_cnt_q <= req_cnt_q + 1'b1;
               end
               if (rsp_take) begin
                  rsp_cnt_q <= rsp_cnt_q + 1'b1;
                  if (rsp_cnt_q == CNT_LAST) begin
                     fill_valid_q <= 1'b1;
                     state_q      <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (bus.fill_ready) begin
                  fill_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Victim line is loaded on acceptance so write beats read it back by
   // index; read responses then overwrite it word by word.
   l1_line_buffer #(
      .WORDS  (BEATS),
      .IDX_W  (BEAT_W),
      .WORD_W (DATA_WIDTH)
   ) u_line_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (miss_take),
      .load_line (bus.wb_data),
      .wr_en     (rsp_take),
      .wr_idx    (rsp_idx),
      .wr_word   (bus.mem_rsp_rdata),
      .rd_idx    (req_idx),
      .rd_word   (rd_word),
      .line      (line)
   );

   assign bus.miss_ready    = (state_q == S_IDLE);
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.mem_req_valid = req_valid;
   assign bus.mem_req_we    = (state_q == S_WB);
   assign bus.mem_req_addr  = (state_q == S_WB)
                              ? {wb_tag_q, fill_addr_q[L1_OFFSET +: L1_INDEX], req_idx, 2'b00}
                              : {fill_addr_q[ADDR_WIDTH-1:L1_OFFSET], req_idx, 2'b00};
   assign bus.mem_req_wdata = rd_word;
   assign bus.fill_valid    = fill_valid_q;
   assign bus.fill_addr     = fill_addr_q;
   assign bus.fill_data     = line;

endmodule

// File: tb/tb_l1_miss_handler.sv
// Directed bench for l1_miss_handler with a small in-order memory model.
module tb_l1_miss_handler;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   l1_miss_handler_if bus ();

   l1_miss_handler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int rsp_delay = 0;
   int ready_mode = 0;
   int pat_idx = 0;
   int stray_cnt = 0;
   int rsp_sent = 0;
   int acc_cyc = -1;
   int fill_cyc = -1;
   int fill_rises = 0;
   int stall_seen = 0;
   logic fill_prev = 1'b0;
   logic [3:0] ready_pat = 4'b1001;

   int          pend_due[$];
   logic [31:0] pend_data[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_wdata[$];
   logic        log_we[$];

   logic        stall_prev = 1'b0;
   logic [31:0] stall_addr;
   logic [31:0] stall_wdata;
   logic        stall_we;

   task automatic chk_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Sample handshakes, stalls, acceptance and fill events mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pend_due.delete();
         pend_data.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk_eq("stall_valid", bus.mem_req_valid, 1'b1);
            chk_eq("stall_addr", bus.mem_req_addr, stall_addr);
            chk_eq("stall_we", bus.mem_req_we, stall_we);
            chk_eq("stall_wdata", bus.mem_req_wdata, stall_wdata);
         end
         stall_prev  = bus.mem_req_valid && !bus.mem_req_ready;
         if (stall_prev) stall_seen++;
         stall_addr  = bus.mem_req_addr;
         stall_we    = bus.mem_req_we;
         stall_wdata = bus.mem_req_wdata;
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            log_addr.push_back(bus.mem_req_addr);
            log_we.push_back(bus.mem_req_we);
            log_wdata.push_back(bus.mem_req_wdata);
            if (!bus.mem_req_we) begin
               pend_due.push_back(cyc + 1 + rsp_delay);
               pend_data.push_back({16'hD00D, bus.mem_req_addr[15:0]});
            end
         end
         if (bus.miss_valid && bus.miss_ready) acc_cyc = cyc;
      end
      if (bus.fill_valid && !fill_prev) begin
         fill_cyc = cyc;
         fill_rises++;
      end
      fill_prev = bus.fill_valid;
   end

   // Drive memory ready and responses for the cycle that is starting.
   always @(posedge clk) begin
      #1;
      if (ready_mode == 1) begin
         bus.mem_req_ready = ready_pat[pat_idx % 4];
         pat_idx++;
      end else begin
         bus.mem_req_ready = 1'b1;
      end
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_rdata = pend_data.pop_front();
         void'(pend_due.pop_front());
         rsp_sent++;
      end else if (stray_cnt > 0) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_rdata = 32'hBAD0_0000 + 32'(stray_cnt);
         stray_cnt--;
      end
   end

   task automatic clear_logs();
      @(negedge clk);
      #1;
      log_addr.delete();
      log_we.delete();
      log_wdata.delete();
   endtask

   task automatic do_miss(input logic [31:0] addr, input logic dirty,
                          input logic [18:0] tag, input logic [255:0] data);
      bit ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      bus.miss_valid = 1'b1;
      bus.miss_addr  = addr;
      bus.wb_en      = dirty;
      bus.wb_tag     = tag;
      bus.wb_data    = data;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bus.miss_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk_eq("miss_accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      bus.miss_valid = 1'b0;
   endtask

   task automatic wait_fill(input logic [31:0] exp_addr);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (bus.fill_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk_eq("fill_timeout", 1'b0, 1'b1);
      end else begin
         chk_eq("fill_addr", bus.fill_addr, exp_addr);
         for (int i = 0; i < 8; i++)
            chk_eq($sformatf("fill_word%0d", i), bus.fill_data[32*i +: 32],
                   {16'hD00D, 16'(exp_addr[15:0] + 16'(4*i))});
      end
      #1;
   endtask

   initial begin
      logic [255:0] d;
      logic [255:0] exp_line;
      int fr;

      rst_n = 1'b0;
      bus.miss_valid    = 1'b0;
      bus.miss_addr     = '0;
      bus.wb_en         = 1'b0;
      bus.wb_tag        = '0;
      bus.wb_data       = '0;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      bus.fill_ready    = 1'b1;

      // Reset values.
      repeat (2) @(negedge clk);
      chk_eq("rst_miss_ready", bus.miss_ready, 1'b1);
      chk_eq("rst_busy", bus.busy, 1'b0);
      chk_eq("rst_req_valid", bus.mem_req_valid, 1'b0);
      chk_eq("rst_fill_valid", bus.fill_valid, 1'b0);
      chk_eq("rst_fill_addr", bus.fill_addr, 32'h0);
      chk_eq("rst_fill_data", bus.fill_data, 256'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_eq("rel_miss_ready", bus.miss_ready, 1'b1);

      // Clean miss, 1-cycle memory.
      clear_logs();
      do_miss(32'h0000_1234, 1'b0, 19'h0, 256'h0);
      wait_fill(32'h0000_1220);
      chk_eq("clean_latency", 32'(fill_cyc - acc_cyc), 32'd10);
      chk_eq("clean_nreq", 32'(log_addr.size()), 32'd8);
      for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
         chk_eq($sformatf("clean_raddr%0d", i), log_addr[i], 32'h1220 + 32'(4*i));
         chk_eq($sformatf("clean_we%0d", i), log_we[i], 1'b0);
      end

      // Dirty miss: write-back then read.
      clear_logs();
      for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'hA0 + 32'(i);
      do_miss(32'h0000_1220, 1'b1, 19'h7FFFF, d);
      wait_fill(32'h0000_1220);
      chk_eq("dirty_nreq", 32'(log_addr.size()), 32'd16);
      for (int i = 0; i < 8 && i + 8 < log_addr.size(); i++) begin
         chk_eq($sformatf("dirty_waddr%0d", i), log_addr[i], 32'hFFFF_F220 + 32'(4*i));
         chk_eq($sformatf("dirty_we%0d", i), log_we[i], 1'b1);
         chk_eq($sformatf("dirty_wdata%0d", i), log_wdata[i], 32'hA0 + 32'(i));
         chk_eq($sformatf("dirty_raddr%0d", i), log_addr[8+i], 32'h1220 + 32'(4*i));
         chk_eq($sformatf("dirty_rwe%0d", i), log_we[8+i], 1'b0);
      end

      // Backpressure 1,0,0,1 and 3-cycle response delay.
      clear_logs();
      rsp_delay  = 3;
      ready_mode = 1;
      pat_idx    = 0;
      stall_seen = 0;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'hB0 + 32'(i);
      do_miss(32'h0000_4A6C, 1'b1, 19'h12345, d);
      wait_fill(32'h0000_4A60);
      chk_eq("bp_stalled", 1'(stall_seen > 0), 1'b1);
      chk_eq("bp_nreq", 32'(log_addr.size()), 32'd16);
      for (int i = 0; i < 8 && i + 8 < log_addr.size(); i++) begin
         chk_eq($sformatf("bp_waddr%0d", i), log_addr[i], 32'h2468_AA60 + 32'(4*i));
         chk_eq($sformatf("bp_wdata%0d", i), log_wdata[i], 32'hB0 + 32'(i));
         chk_eq($sformatf("bp_raddr%0d", i), log_addr[8+i], 32'h4A60 + 32'(4*i));
      end
      @(negedge clk);
      #1;
      ready_mode = 0;
      rsp_delay  = 0;

      // fill_ready held low; a waiting miss must not be taken early.
      clear_logs();
      for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hD00D_2000 + 32'(4*i);
      @(posedge clk);
      #1 bus.fill_ready = 1'b0;
      do_miss(32'h0000_2000, 1'b0, 19'h0, 256'h0);
      wait_fill(32'h0000_2000);
      @(posedge clk);
      #1;
      bus.miss_valid = 1'b1;
      bus.miss_addr  = 32'h0000_3000;
      bus.wb_en      = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk_eq($sformatf("hold_valid%0d", k), bus.fill_valid, 1'b1);
         chk_eq($sformatf("hold_addr%0d", k), bus.fill_addr, 32'h0000_2000);
         chk_eq($sformatf("hold_data%0d", k), bus.fill_data, exp_line);
         chk_eq($sformatf("hold_miss_ready%0d", k), bus.miss_ready, 1'b0);
      end
      @(posedge clk);
      #1 bus.fill_ready = 1'b1;
      @(negedge clk);
      chk_eq("hs_fill_valid", bus.fill_valid, 1'b1);
      chk_eq("hs_miss_ready", bus.miss_ready, 1'b0);
      @(negedge clk);
      chk_eq("post_fill_valid", bus.fill_valid, 1'b0);
      chk_eq("post_miss_ready", bus.miss_ready, 1'b1);
      chk_eq("post_busy", bus.busy, 1'b0);
      @(posedge clk);
      #1 bus.miss_valid = 1'b0;
      @(negedge clk);
      chk_eq("next_busy", bus.busy, 1'b1);
      chk_eq("next_req_valid", bus.mem_req_valid, 1'b1);
      chk_eq("next_req_addr", bus.mem_req_addr, 32'h0000_3000);
      wait_fill(32'h0000_3000);

      // Reset mid-read, then stray responses.
      clear_logs();
      rsp_sent = 0;
      do_miss(32'h0000_5000, 1'b0, 19'h0, 256'h0);
      begin
         bit ok;
         ok = 1'b0;
         for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rsp_sent >= 4) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) chk_eq("rsp4_timeout", 1'b0, 1'b1);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_eq("mid_rst_busy", bus.busy, 1'b0);
      chk_eq("mid_rst_miss_ready", bus.miss_ready, 1'b1);
      chk_eq("mid_rst_req_valid", bus.mem_req_valid, 1'b0);
      chk_eq("mid_rst_fill_valid", bus.fill_valid, 1'b0);
      chk_eq("mid_rst_fill_addr", bus.fill_addr, 32'h0);
      chk_eq("mid_rst_fill_data", bus.fill_data, 256'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      stray_cnt = 4;
      fr = fill_rises;
      repeat (8) @(negedge clk);
      #1;
      chk_eq("stray_busy", bus.busy, 1'b0);
      chk_eq("stray_miss_ready", bus.miss_ready, 1'b1);
      chk_eq("stray_fill_valid", bus.fill_valid, 1'b0);
      chk_eq("stray_fill_data", bus.fill_data, 256'h0);
      chk_eq("stray_no_fill", 32'(fill_rises), 32'(fr));
      do_miss(32'h0000_6040, 1'b0, 19'h0, 256'h0);
      wait_fill(32'h0000_6040);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/l1_miss_handler.md
L1_MISS_HANDLER -- requirements
Module: l1_miss_handler

Interface
REQ-001 Parameter BEATS, default L1_LINE_SIZE/(DATA_WIDTH/8) (= 8), words per line transfer.
REQ-002 Parameter BEAT_W, default $clog2(BEATS) (= 3), beat counter index width.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 miss_valid  in  1  L1 controller presents a miss.
REQ-006 miss_ready  out  1  handler accepts a miss; high only in IDLE.
REQ-007 miss_addr  in  ADDR_WIDTH  missing address; low L1_OFFSET bits ignored.
REQ-008 wb_en  in  1  victim line dirty, write back first.
REQ-009 wb_tag  in  L1_TAG  victim tag.
REQ-010 wb_data  in  L1_DATABITS  victim line; word i at bits [32*i +: 32].
REQ-011 mem_req_valid / mem_req_ready  out / in  1 / 1  next-level request handshake.
REQ-012 mem_req_we  out  1  1 = write beat, 0 = read beat.
REQ-013 mem_req_addr  out  ADDR_WIDTH  word address of the beat.
REQ-014 mem_req_wdata  out  DATA_WIDTH  write data.
REQ-015 mem_rsp_valid  in  1  read data beat; in order; no backpressure.
REQ-016 mem_rsp_rdata  in  DATA_WIDTH  read data.
REQ-017 fill_valid / fill_ready  out / in  1 / 1  refill-line handshake to L1.
REQ-018 fill_addr  out  ADDR_WIDTH  line-aligned refill address (offset bits 0).
REQ-019 fill_data  out  L1_DATABITS  assembled line; word i at [32*i +: 32].
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 States: IDLE, WB, RD, FILL; one miss in flight at a time.
REQ-022 IDLE: miss_valid&&miss_ready captures miss_addr line, wb_tag, wb_data; next state WB if wb_en, else RD.
REQ-023 WB: issues BEATS write requests, beat i address = {wb_tag, captured index, i[BEAT_W-1:0], 2'b00}, wdata = word i; beat counter advances only on mem_req_valid&&mem_req_ready.
REQ-024 WB -> RD in the cycle after the last write handshake; no write response is expected.
REQ-025 RD: issues BEATS read requests, address = {line, i, 2'b00}; responses are collected concurrently by an independent response counter; word k written to fill_data[32*k +: 32].
REQ-026 Request counter and response counter are separate; a request and a response in the same cycle both advance.
REQ-027 mem_req_valid deasserts once all BEATS requests of the current phase have been accepted.
REQ-028 RD -> FILL in the cycle after the BEATS-th response is captured; fill_valid rises that cycle.
REQ-029 FILL: fill_valid, fill_addr and fill_data are held stable until fill_ready; on handshake return to IDLE; miss_ready is high the following cycle.
REQ-030 mem_req_* stays stable while mem_req_valid && !mem_req_ready.
REQ-031 mem_rsp_valid outside RD, or after BEATS responses, is ignored and does not change state or data.
REQ-032 Minimum latency, clean miss with 1-cycle memory: fill_valid asserts 1 + BEATS + 1 cycles after miss acceptance.

Reset
REQ-033 rst_n low asynchronously forces IDLE, clears both counters, mem_req_valid=0, fill_valid=0, busy=0, fill_data=0, fill_addr=0.
REQ-034 miss_ready=1 during reset and in the first cycle after release.
REQ-035 Reset during WB/RD/FILL abandons the transaction and loses no state beyond it; responses arriving after release are dropped per REQ-031.

Structure
REQ-036 L1_BEATS, L1_BEAT_BITS and typedef enum l1_mh_state_t {IDLE, WB, RD, FILL} belong in cache_pkg.
REQ-037 Line assembly and word select are isolated in one sub-module, l1_line_buffer (write-word-by-index, read-word-by-index, full line out).

Verification
REQ-038 Clean miss at 0x0000_1234 with 1-cycle memory -> reads at 0x1220, 0x1224 … 0x123C; fill_addr=0x0000_1220; fill_valid 10 cycles after acceptance.
REQ-039 Dirty miss, wb_tag=0x7FFFF, index 0x91, wb_data word i = 0xA0+i -> 8 writes at 0xFFFF_F220…0xFFFF_F23C with data 0xA0…0xA7, then 8 reads.
REQ-040 mem_req_ready toggling 1,0,0,1 and responses delayed 3 cycles -> address/wdata stable while stalled; fill_data word i equals the i-th response.
REQ-041 fill_ready held low 5 cycles -> fill_valid/fill_data stable; miss_valid held high is not accepted until the cycle after the fill handshake.
REQ-042 rst_n pulsed low after 4th read response, then 4 stray responses -> IDLE, busy=0, fill_valid never asserts, next miss completes correctly.
